readout_capture: RTL

- Consumer end of the pixel readout sequence. Watches the 3-bit readout phase code issued by the readout timer and samples the ADC bus during the ADC_1 (reset level) and ADC_2 (signal level) phases.
- On END, computes the correlated-double-sample difference (signal − reset) and pushes it into a small first-word-fall-through FIFO.
- The FIFO is drained by the downstream frame/serializer logic via a valid/ready handshake.

---
 rtl/readout_capture.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/readout_capture.sv
// ---------------------------------------------------------------------------
// readout_capture
//   Consumer end of the pixel readout sequence. Samples the ADC bus during the
//   ADC_1 (reset level) and ADC_2 (signal level) phases, and on END pushes the
//   correlated-double-sample difference (signal - reset) into a small
//   first-word-fall-through FIFO drained through a valid/ready handshake.
//
//   Optional build macro: CDS_CLAMP_EN
//     defined   : negative differences are stored as zero
//     undefined : the raw signed DATA_W+1 bit difference is stored
// ---------------------------------------------------------------------------
module readout_capture #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [2:0]        i_RD_FSM,
    input  logic [DATA_W-1:0] i_ADC_Data,
    output logic [DATA_W:0]   o_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Busy,
    output logic              o_Overflow,
    output logic              o_Seq_Err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Readout phase codes issued by the readout timer.
    localparam logic [2:0] CODE_INIT    = 3'b000;
    localparam logic [2:0] CODE_ADC_1   = 3'b010;
    localparam logic [2:0] CODE_ADC_2   = 3'b101;
    localparam logic [2:0] CODE_END     = 3'b110;
    localparam logic [2:0] CODE_UNUSED  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_A = 2'd1,
        ST_GOT_B = 2'd2
    } state_t;

    // CDS difference of the two samples; optionally clamped at zero.
    function automatic logic [DATA_W:0] calc_cds(
        input logic [DATA_W-1:0] reset_lvl,
        input logic [DATA_W-1:0] signal_lvl
    );
        logic [DATA_W:0] diff;
        diff = {1'b0, signal_lvl} - {1'b0, reset_lvl};
`ifdef CDS_CLAMP_EN
        if (signal_lvl < reset_lvl) begin
            diff = {(DATA_W+1){1'b0}};
        end else begin
            diff = {1'b0, signal_lvl} - {1'b0, reset_lvl};
        end
`endif
        return diff;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [2:0]              code_s;
    logic                    load_a_s;
    logic                    load_b_s;
    logic                    push_s;
    logic                    seq_err_set_s;

    logic [DATA_W-1:0]       a_r;
    logic [DATA_W-1:0]       b_r;
    logic [DATA_W:0]         cds_s;

    logic [DATA_W:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_next_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_next_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_accept_s;
    logic                    overflow_set_s;
    logic [DATA_W:0]         head_next_s;

    // Fold the unused code onto INIT so the FSM only sees defined phases.
    always_comb begin
        code_s = i_RD_FSM;
        if (i_RD_FSM == CODE_UNUSED) begin
            code_s = CODE_INIT;
        end else begin
            code_s = i_RD_FSM;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture FSM next-state and sample/push strobes.
    always_comb begin
        state_next_s  = state_r;
        load_a_s      = 1'b0;
        load_b_s      = 1'b0;
        push_s        = 1'b0;
        seq_err_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                case (code_s)
                    CODE_ADC_1: begin
                        load_a_s     = 1'b1;
                        state_next_s = ST_GOT_A;
                    end
                    CODE_ADC_2, CODE_END: begin
                        seq_err_set_s = 1'b1;
                    end
                    default: begin
                        state_next_s = ST_IDLE;
                    end
                endcase
            end
            ST_GOT_A: begin
                case (code_s)
                    CODE_ADC_1: begin
                        load_a_s = 1'b1;
                    end
                    CODE_ADC_2: begin
                        load_b_s     = 1'b1;
                        state_next_s = ST_GOT_B;
                    end
                    CODE_END: begin
                        seq_err_set_s = 1'b1;
                        state_next_s  = ST_IDLE;
                    end
                    CODE_INIT: begin
                        state_next_s = ST_IDLE;
                    end
                    default: begin
                        state_next_s = ST_GOT_A;
                    end
                endcase
            end
            ST_GOT_B: begin
                case (code_s)
                    CODE_ADC_2: begin
                        load_b_s = 1'b1;
                    end
                    CODE_END: begin
                        push_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                    CODE_INIT: begin
                        state_next_s = ST_IDLE;
                    end
                    CODE_ADC_1: begin
                        seq_err_set_s = 1'b1;
                        load_a_s      = 1'b1;
                        state_next_s  = ST_GOT_A;
                    end
                    default: begin
                        state_next_s = ST_GOT_B;
                    end
                endcase
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Reset-level (A) and signal-level (B) sample registers; last write wins.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            a_r <= {DATA_W{1'b0}};
            b_r <= {DATA_W{1'b0}};
        end else begin
            if (load_a_s) begin
                a_r <= i_ADC_Data;
            end
            if (load_b_s) begin
                b_r <= i_ADC_Data;
            end
        end
    end

    assign cds_s = calc_cds(a_r, b_r);

    // FIFO control: handshake, accept/drop decision and next occupancy.
    always_comb begin
        pop_s          = o_Valid & i_Ready;
        full_s         = (count_r == CNT_W'(FIFO_DEPTH));
        push_accept_s  = push_s & (~full_s | pop_s);
        overflow_set_s = push_s & full_s & ~pop_s;
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_accept_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Head entry after this edge; a write landing on the new head is forwarded.
    always_comb begin
        head_next_s = {(DATA_W+1){1'b0}};
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_next_s = {(DATA_W+1){1'b0}};
        end else if (push_accept_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = cds_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(DATA_W+1){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_accept_s) begin
                mem_r[wr_ptr_r] <= cds_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Registered outputs: FIFO head, valid, busy and sticky error flags.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Data     <= {(DATA_W+1){1'b0}};
            o_Valid    <= 1'b0;
            o_Busy     <= 1'b0;
            o_Overflow <= 1'b0;
            o_Seq_Err  <= 1'b0;
        end else begin
            o_Data     <= head_next_s;
            o_Valid    <= (count_next_s != {CNT_W{1'b0}});
            o_Busy     <= (state_next_s != ST_IDLE);
            o_Overflow <= o_Overflow | overflow_set_s;
            o_Seq_Err  <= o_Seq_Err | seq_err_set_s;
        end
    end

endmodule
